sd_spi_responder: RTL

- Card-side end of the SD SPI-mode link: decodes 48-bit command frames that a host drives on SCK/CS/MOSI and returns an R1 response byte on MISO.
- Used to emulate or instrument an SD card behind the FTDI-to-SD pin path, so host tooling can be exercised without a physical card.
- Exposes a command/response handshake to local logic.
- Validates CRC7 on incoming frames.

---
 rtl/sd_spi_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_responder.sv
// SD SPI-mode card-side responder: decodes 48-bit command frames,
// checks CRC7 and returns an R1 byte supplied by local logic.
module sd_spi_responder #(
  parameter int         NCR_MIN    = 1,
  parameter int         NCR_MAX    = 8,
  parameter bit         CRC_CHECK  = 1'b1,
  parameter logic [7:0] CRC_ERR_R1 = 8'h08
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_sck,
  input  logic        sd_cs_n,
  input  logic        sd_mosi,
  output logic        sd_miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_err,
  input  logic        resp_valid,
  input  logic [7:0]  resp_data,
  output logic        resp_taken,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, CMD, CHECK, WAIT, SEND
  } state_t;

  localparam logic [7:0] MIN8 = NCR_MIN[7:0];
  localparam logic [7:0] MAX8 = NCR_MAX[7:0];

  state_t      state;
  logic [1:0]  sck_q, cs_q, mosi_q;
  logic        sck_d;
  logic [47:0] sr;
  logic [5:0]  bit_cnt;
  logic [7:0]  fill_cnt;
  logic        armed, boundary, have;
  logic [7:0]  resp_q;

  logic sck_rise, sck_fall, cs_n, bit_in, frame_ok;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign sck_rise = sck_q[1] & ~sck_d;
  assign sck_fall = ~sck_q[1] & sck_d;
  assign cs_n     = cs_q[1];
  assign bit_in   = mosi_q[1];
  assign busy     = (state != IDLE);
  assign frame_ok = sr[0] &&
    (!CRC_CHECK || crc7(sr[47:8]) == sr[7:1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q  <= 2'b00;
      cs_q   <= 2'b11;
      mosi_q <= 2'b11;
      sck_d  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[0], sd_sck};
      cs_q   <= {cs_q[0], sd_cs_n};
      mosi_q <= {mosi_q[0], sd_mosi};
      sck_d  <= sck_q[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sd_miso    <= 1'b1;
      cmd_valid  <= 1'b0;
      crc_err    <= 1'b0;
      resp_taken <= 1'b0;
      cmd_index  <= 6'd0;
      cmd_arg    <= 32'd0;
      sr         <= 48'd0;
      bit_cnt    <= 6'd0;
      fill_cnt   <= 8'd0;
      armed      <= 1'b0;
      boundary   <= 1'b0;
      have       <= 1'b0;
      resp_q     <= 8'hFF;
    end else begin
      cmd_valid  <= 1'b0;
      crc_err    <= 1'b0;
      resp_taken <= 1'b0;
      if (cs_n) begin
        state    <= IDLE;
        sd_miso  <= 1'b1;
        bit_cnt  <= 6'd0;
        fill_cnt <= 8'd0;
        armed    <= 1'b0;
        boundary <= 1'b0;
        have     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (sck_rise) begin
            // bit-aligned hunt for the 0,1 start/transmission pair
            if (armed && bit_in) begin
              state   <= CMD;
              sr      <= {46'd0, 2'b01};
              bit_cnt <= 6'd2;
              armed   <= 1'b0;
            end else if (!bit_in) begin
              armed <= 1'b1;
            end
          end
          CMD: if (sck_rise) begin
            sr      <= {sr[46:0], bit_in};
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd47) state <= CHECK;
          end
          CHECK: begin
            if (frame_ok) begin
              cmd_index <= sr[45:40];
              cmd_arg   <= sr[39:8];
              cmd_valid <= 1'b1;
              have      <= 1'b0;
            end else begin
              crc_err <= 1'b1;
              resp_q  <= CRC_ERR_R1;
              have    <= 1'b1;
            end
            bit_cnt  <= 6'd0;
            fill_cnt <= 8'd0;
            boundary <= 1'b0;
            state    <= WAIT;
          end
          WAIT: begin
            if (!have && resp_valid) begin
              resp_q     <= resp_data;
              have       <= 1'b1;
              resp_taken <= 1'b1;
            end
            if (sck_rise) begin
              if (bit_cnt == 6'd7) begin
                bit_cnt  <= 6'd0;
                fill_cnt <= fill_cnt + 8'd1;
                boundary <= 1'b1;
                if (fill_cnt + 8'd1 >= MAX8 && !have && !resp_valid)
                  state <= IDLE;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end else if (sck_fall && boundary) begin
              boundary <= 1'b0;
              if (fill_cnt >= MIN8 && have) begin
                sd_miso <= resp_q[7];
                bit_cnt <= 6'd1;
                state   <= SEND;
              end
            end
          end
          SEND: if (sck_fall) begin
            if (bit_cnt == 6'd8) begin
              sd_miso <= 1'b1;
              bit_cnt <= 6'd0;
              state   <= IDLE;
            end else begin
              sd_miso <= resp_q[3'd7 - bit_cnt[2:0]];
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
